// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: default active-area size and sprite motion modes.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    MODE_HOME   = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

endpackage

// File: rtl/bounce_axis.sv
// One axis of sprite motion: position and direction registers plus wall detection.
// Both registers only move on tick, so the sprite never tears mid-frame.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = 512,
  parameter int STEP  = 1,
  parameter int HOME  = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] mode,
  output logic [9:0] pos,
  output logic       wall
);

  logic [9:0]  pos_q, pos_d;
  logic        dir_q, dir_d;
  logic [10:0] step_up;

  // Compare at 11 bits so pos+STEP never wraps before the limit test.
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    wall    = 1'b0;
    step_up = {1'b0, pos_q} + 11'(STEP);
    if (tick) begin
      case (mode)
        MODE_HOME: begin
          pos_d = 10'(HOME);
          dir_d = 1'b1;
        end
        MODE_BOUNCE, MODE_ROTATE: begin
          if (dir_q) begin
            if (step_up >= 11'(LIMIT)) begin
              pos_d = 10'(LIMIT);
              dir_d = 1'b0;
              wall  = 1'b1;
            end else begin
              pos_d = step_up[9:0];
            end
          end else if ({1'b0, pos_q} <= 11'(STEP)) begin
            pos_d = 10'd0;
            dir_d = 1'b1;
            wall  = 1'b1;
          end else begin
            pos_d = pos_q - 10'(STEP);
          end
        end
        MODE_FREEZE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= 10'(HOME);
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/vga_bounce_sprite.sv
// Scaled ROM sprite renderer with per-frame edge bouncing and palette rotation.
// Two-stage pipeline: address/in_box/sync stage, then colour index stage.
module vga_bounce_sprite
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int COLS_LOG2    = 4,
  parameter int ROWS_LOG2    = 7,
  parameter int SCALE_X_LOG2 = 3,
  parameter int SCALE_Y_LOG2 = 0,
  parameter int PIX_BITS     = 3,
  parameter int STEP         = 1,
  parameter int HOME_X       = 256,
  parameter int HOME_Y       = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  input  logic                 display_on,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [1:0]           mode,
  output logic [COLS_LOG2-1:0] rom_x,
  output logic [ROWS_LOG2-1:0] rom_y,
  input  logic [PIX_BITS-1:0]  rom_pixel,
  output logic [PIX_BITS-1:0]  pix_index,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 de_out,
  output logic                 hit
);

  localparam int W = 1 << (COLS_LOG2 + SCALE_X_LOG2);
  localparam int H = 1 << (ROWS_LOG2 + SCALE_Y_LOG2);
  localparam logic [PIX_BITS:0] PIX_MOD = (PIX_BITS + 1)'((1 << PIX_BITS) - 1);

  logic                 frame_tick;
  logic [9:0]           x0, y0;
  logic                 wall_x, wall_y;
  logic [10:0]          off_x, off_y;
  logic [PIX_BITS:0]    rot_sum;
  logic [PIX_BITS-1:0]  rot_pix;

  logic [COLS_LOG2-1:0] rom_x_q, rom_x_d;
  logic [ROWS_LOG2-1:0] rom_y_q, rom_y_d;
  logic                 in_box_q, in_box_d;
  logic                 de1_q, de1_d, de2_q, de2_d;
  logic                 hs1_q, hs1_d, hs2_q, hs2_d;
  logic                 vs1_q, vs1_d, vs2_q, vs2_d;
  logic [PIX_BITS-1:0]  pix_q, pix_d;
  logic [PIX_BITS-1:0]  rot_q, rot_d;
  logic                 hit_q, hit_d;

  assign frame_tick = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));

  bounce_axis #(.LIMIT(H_ACTIVE - W), .STEP(STEP), .HOME(HOME_X)) u_axis_x (
    .clk   (clk),
    .reset (reset),
    .tick  (frame_tick),
    .mode  (mode),
    .pos   (x0),
    .wall  (wall_x)
  );

  bounce_axis #(.LIMIT(V_ACTIVE - H), .STEP(STEP), .HOME(HOME_Y)) u_axis_y (
    .clk   (clk),
    .reset (reset),
    .tick  (frame_tick),
    .mode  (mode),
    .pos   (y0),
    .wall  (wall_y)
  );

  always_comb begin
    off_x    = {1'b0, hpos} - {1'b0, x0};
    off_y    = {1'b0, vpos} - {1'b0, y0};
    in_box_d = ({1'b0, hpos} >= {1'b0, x0}) && ({1'b0, hpos} < ({1'b0, x0} + 11'(W))) &&
               ({1'b0, vpos} >= {1'b0, y0}) && ({1'b0, vpos} < ({1'b0, y0} + 11'(H)));
    rom_x_d  = COLS_LOG2'(off_x >> SCALE_X_LOG2);
    rom_y_d  = ROWS_LOG2'(off_y >> SCALE_Y_LOG2);
    de1_d    = display_on;
    hs1_d    = hsync_in;
    vs1_d    = vsync_in;
    de2_d    = de1_q;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;

    // Rotate within 1..2^PIX_BITS-1 so transparent index 0 is never produced.
    rot_sum = {1'b0, rom_pixel} - (PIX_BITS + 1)'(1) + {1'b0, rot_q};
    if (rot_sum >= PIX_MOD) begin
      rot_sum = rot_sum - PIX_MOD;
    end
    rot_pix = PIX_BITS'(rot_sum) + PIX_BITS'(1);
    pix_d   = (de1_q && in_box_q && (rom_pixel != '0)) ? rot_pix : '0;

    hit_d = frame_tick && (wall_x || wall_y);
    rot_d = rot_q;
    if (frame_tick) begin
      if (mode == MODE_HOME) begin
        rot_d = '0;
      end else if ((mode == MODE_ROTATE) && (wall_x || wall_y)) begin
        rot_d = rot_q + PIX_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_x_q  <= '0;
      rom_y_q  <= '0;
      in_box_q <= 1'b0;
      de1_q    <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      de2_q    <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      pix_q    <= '0;
      rot_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      rom_x_q  <= rom_x_d;
      rom_y_q  <= rom_y_d;
      in_box_q <= in_box_d;
      de1_q    <= de1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      de2_q    <= de2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      pix_q    <= pix_d;
      rot_q    <= rot_d;
      hit_q    <= hit_d;
    end
  end

  assign rom_x     = rom_x_q;
  assign rom_y     = rom_y_q;
  assign pix_index = pix_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign de_out    = de2_q;
  assign hit       = hit_q;

endmodule

// File: doc/vga_bounce_sprite.md
# vga_bounce_sprite

Parametrised sprite renderer for the VGA pipeline, sitting between the sync generator and the palette/PMOD output stage. It places a ROM-backed bitmap at a programmable position and scale, and optionally moves it, bouncing off the screen edges once per frame. On each wall hit it can rotate the palette indices.
- Output: a pipelined colour index, plus sync and data-enable delayed to match.

## Interface
Parameters:
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- COLS_LOG2, 4, log2 bitmap columns (texels)
- ROWS_LOG2, 7, log2 bitmap rows
- SCALE_X_LOG2, 3, log2 horizontal pixels per texel
- SCALE_Y_LOG2, 0, log2 vertical pixels per texel
- PIX_BITS, 3, colour-index width
- STEP, 1, pixels moved per frame per axis
- HOME_X, 256, reset/home left edge
- HOME_Y, 128, reset/home top edge

Ports (clock and reset first):
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hpos  in  10  current column from sync generator
- vpos  in  10  current row from sync generator
- display_on  in  1  visible-area flag
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- mode  in  2  00 home, 01 bounce, 10 bounce+rotate, 11 freeze
- rom_x  out  COLS_LOG2  registered texel column to bitmap ROM
- rom_y  out  ROWS_LOG2  registered texel row to bitmap ROM
- rom_pixel  in  PIX_BITS  combinational ROM data for (rom_x, rom_y)
- pix_index  out  PIX_BITS  colour index; 0 = background
- hsync_out  out  1  hsync delayed 2 cycles
- vsync_out  out  1  vsync delayed 2 cycles
- de_out  out  1  display_on delayed 2 cycles
- hit  out  1  one-cycle pulse on any wall bounce

## Operation
- Sprite size: W = 2^(COLS_LOG2+SCALE_X_LOG2), H = 2^(ROWS_LOG2+SCALE_Y_LOG2). With the defaults, W = H = 128.
- State: x0 (10 b), y0 (10 b), dx, dy (1 = increasing), rot (PIX_BITS).
- Reset values: x0=HOME_X, y0=HOME_Y, dx=dy=1, rot=0.
- frame_tick = (hpos==0 && vpos==V_ACTIVE). It fires once per frame, in vblank. Position, direction and rot change only on frame_tick, so no mid-frame tearing. `mode` is sampled only at frame_tick.
- Mode 00: x0=HOME_X, y0=HOME_Y, dx=dy=1, rot=0.
- Mode 11: all state held.
- Modes 01/10, per axis (X shown; Y identical with V_ACTIVE−H):
  - dx=1 and x0+STEP ≥ H_ACTIVE−W → x0=H_ACTIVE−W, dx=0, axis hit.
  - dx=0 and x0 ≤ STEP → x0=0, dx=1, axis hit.
  - Otherwise x0 ± STEP.
- hit is asserted the cycle after frame_tick if either axis hit. A corner hit on both axes gives a single pulse.
- Mode 10: rot increments by 1 (mod 2^PIX_BITS) per hit pulse.
- in_box = hpos ∈ [x0, x0+W) and vpos ∈ [y0, y0+H). Comparisons are unsigned, computed at 11 bits so they cannot overflow.
- rom_x = (hpos−x0)[SCALE_X_LOG2 +: COLS_LOG2]; rom_y = (vpos−y0)[SCALE_Y_LOG2 +: ROWS_LOG2].
- pix_index:
  - 0 unless display_on and in_box (both delayed).
  - rom_pixel==0 → 0; 0 marks a transparent texel and is never rotated.
  - Otherwise ((rom_pixel−1+rot) mod (2^PIX_BITS−1))+1.
- Reset mid-frame: state returns to home on the next edge, and the pipeline is flushed to 0.

## Timing
- Stage 1 (n→n+1): register rom_x, rom_y, in_box, and the first delay stage of display_on/hsync/vsync.
- Stage 2 (n+1→n+2): register pix_index from rom_pixel, plus the second delay stage.
- Total latency: hpos/vpos at cycle n → pix_index at n+2. Sync and de_out are delayed by exactly the same amount.
- Reset value of all outputs: 0, including rom_x, rom_y, hit and the sync outputs.
- hit goes high one cycle after frame_tick.
- The new position applies from the first pixel after frame_tick (row 0 of the next frame).

## Structure
- Shared package `vga_pkg`: H_ACTIVE/V_ACTIVE defaults and the mode encodings MODE_HOME, MODE_BOUNCE, MODE_ROTATE, MODE_FREEZE.
- One sub-module, `bounce_axis`: position and direction register plus wall detection, parametrised by limit, STEP and HOME. It is instantiated once for X and once for Y.
- The pipeline and rotation stay in the top.

## Test plan
- After reset, in mode 01 with a constant-5 ROM: pixel (256,128) → pix_index=5 two cycles later; pixels (255,128) and (384,128) → 0; hsync_out equals hsync_in delayed 2.
- Mode 01 for 3 frames: x0=259, y0=131; no change mid-frame.
- Bounce limits with STEP=1 and x0 preset near 512 by running frames: x0 saturates at 512, dx flips, hit pulses once; the next frame gives x0=511.
- Mode 10 with rom_pixel=7, PIX_BITS=3, after one hit (rot=1): pix_index=1 (wrap, skipping 0); rom_pixel=0 → 0.
- Corner case HOME_X=512, HOME_Y=352: both axes hit on the same frame → a single hit pulse and rot+1.
- Mode switch to 11 then 00 mid-frame: position holds until frame_tick, then returns to (256,128) with rot=0. Asserting reset mid-line → outputs 0 on the next edge.
